// File: rtl/trap_sequencer.sv
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
// Trap/mret sequencer: arbitrates pipeline exception reports and mret, latches the
// winning trap for the CSR file, and walks the pipeline through flush and PC redirect.
module trap_sequencer #(
   parameter int XLEN         = `XLEN_64b,
   parameter int FLUSH_CYCLES = 2,
   localparam int W           = 1 << (XLEN + 4)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clk_en,
   input  logic         i_exc_valid_f_d,
   input  logic [3:0]   i_exc_code_f_d,
   input  logic [W-1:0] i_exc_pc_f_d,
   input  logic         i_exc_valid_e_m,
   input  logic [3:0]   i_exc_code_e_m,
   input  logic [W-1:0] i_exc_pc_e_m,
   input  logic [W-1:0] i_exc_addr_e_m,
   input  logic         i_mret_d,
   input  logic [W-1:0] i_mtvec,
   input  logic [W-1:0] i_mepc,
   output logic         o_exc_valid_f_d_ff,
   output logic [3:0]   o_exception_code_f_d_ff,
   output logic [W-1:0] o_exception_pc_f_d_ff,
   output logic         o_exc_valid_e_m_ff,
   output logic [3:0]   o_exception_code_e_m_ff,
   output logic [W-1:0] o_exception_pc_e_m_ff,
   output logic [W-1:0] o_exception_addr_e_m_ff,
   output logic         o_mret_e,
   output logic         o_flush,
   output logic         o_stall_pc,
   output logic         o_pc_redirect,
   output logic [W-1:0] o_redirect_target,
   output logic         o_busy
);

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      TRAP_FLUSH    = 2'd1,
      TRAP_REDIRECT = 2'd2,
      MRET_REDIRECT = 2'd3
   } state_t;

   localparam logic [3:0]   CNT_LAST  = 4'(FLUSH_CYCLES - 1);
   localparam logic [W-1:0] BASE_MASK = {{(W-2){1'b1}}, 2'b00};

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       take_em, take_fd;

   // Requests are only looked at in IDLE; anything seen later belongs to a squashed instruction.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      take_em  = 1'b0;
      take_fd  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = 4'd0;
            if (i_exc_valid_e_m) begin
               take_em  = 1'b1;
               state_nx = TRAP_FLUSH;
            end else if (i_exc_valid_f_d) begin
               take_fd  = 1'b1;
               state_nx = TRAP_FLUSH;
            end else if (i_mret_d) begin
               state_nx = MRET_REDIRECT;
            end
         end
         TRAP_FLUSH: begin
            if (cnt == CNT_LAST) begin
               cnt_nx   = 4'd0;
               state_nx = TRAP_REDIRECT;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         TRAP_REDIRECT: state_nx = IDLE;
         MRET_REDIRECT: state_nx = IDLE;
         default:       state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state                   <= IDLE;
         cnt                     <= 4'd0;
         o_exc_valid_f_d_ff      <= 1'b0;
         o_exception_code_f_d_ff <= 4'd0;
         o_exception_pc_f_d_ff   <= '0;
         o_exc_valid_e_m_ff      <= 1'b0;
         o_exception_code_e_m_ff <= 4'd0;
         o_exception_pc_e_m_ff   <= '0;
         o_exception_addr_e_m_ff <= '0;
      end else if (i_clk_en) begin
         state              <= state_nx;
         cnt                <= cnt_nx;
         o_exc_valid_e_m_ff <= take_em;
         o_exc_valid_f_d_ff <= take_fd;
         if (take_em) begin
            o_exception_code_e_m_ff <= i_exc_code_e_m;
            o_exception_pc_e_m_ff   <= i_exc_pc_e_m;
            o_exception_addr_e_m_ff <= i_exc_addr_e_m;
         end
         if (take_fd) begin
            o_exception_code_f_d_ff <= i_exc_code_f_d;
            o_exception_pc_f_d_ff   <= i_exc_pc_f_d;
         end
      end
   end

   // Moore decode; targets stay live so a CSR write in the trap cycle is honoured.
   always_comb begin
      o_busy            = (state != IDLE);
      o_flush           = (state != IDLE);
      o_stall_pc        = (state == TRAP_FLUSH);
      o_pc_redirect     = (state == TRAP_REDIRECT) || (state == MRET_REDIRECT);
      o_mret_e          = (state == MRET_REDIRECT);
      o_redirect_target = '0;
      if (state == TRAP_REDIRECT) o_redirect_target = i_mtvec & BASE_MASK;
      if (state == MRET_REDIRECT) o_redirect_target = i_mepc;
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a sequence-level reference model schedules expected commit
// and redirect events into a queue; a monitor pops them as the DUT presents them.
module tb_trap_sequencer;
   localparam int W     = 64;
   localparam int FLUSH = 2;

   logic         clk = 1'b0;
   logic         rst, en;
   logic         fd_v, em_v, mret;
   logic [3:0]   fd_code, em_code;
   logic [W-1:0] fd_pc, em_pc, em_addr, mtvec, mepc;
   logic         s_fd, s_em, mret_e, flush, stall, redir, busy;
   logic [3:0]   r_fd_code, r_em_code;
   logic [W-1:0] r_fd_pc, r_em_pc, r_em_addr, target;

   trap_sequencer #(.XLEN(2), .FLUSH_CYCLES(FLUSH)) dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(en),
      .i_exc_valid_f_d(fd_v), .i_exc_code_f_d(fd_code), .i_exc_pc_f_d(fd_pc),
      .i_exc_valid_e_m(em_v), .i_exc_code_e_m(em_code), .i_exc_pc_e_m(em_pc),
      .i_exc_addr_e_m(em_addr), .i_mret_d(mret), .i_mtvec(mtvec), .i_mepc(mepc),
      .o_exc_valid_f_d_ff(s_fd), .o_exception_code_f_d_ff(r_fd_code),
      .o_exception_pc_f_d_ff(r_fd_pc), .o_exc_valid_e_m_ff(s_em),
      .o_exception_code_e_m_ff(r_em_code), .o_exception_pc_e_m_ff(r_em_pc),
      .o_exception_addr_e_m_ff(r_em_addr), .o_mret_e(mret_e), .o_flush(flush),
      .o_stall_pc(stall), .o_pc_redirect(redir), .o_redirect_target(target), .o_busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard
   typedef struct {
      int         kind;      // 1 E/M commit, 2 F/D commit, 3 trap redirect, 4 mret redirect
      int         edge_idx;
      logic [3:0] code;
      logic [W-1:0] pc;
      logic [W-1:0] addr;
   } ev_t;
   ev_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // reference model state: which sequence is running and how many enabled edges since accept
   int           seq_kind = 0;   // 0 none, 1 trap, 2 mret
   int           seq_win  = 0;   // 1 E/M, 2 F/D
   int           seq_age  = 0;
   int           edge_cnt = 0;
   bit           fresh    = 1'b0;
   logic [3:0]   sh_fd_code = '0, sh_em_code = '0;
   logic [W-1:0] sh_fd_pc = '0, sh_em_pc = '0, sh_em_addr = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      ev_t e;
      if (!rst) begin
         seq_kind = 0; seq_age = 0; fresh = 1'b0;
         sh_fd_code = '0; sh_fd_pc = '0; sh_em_code = '0; sh_em_pc = '0; sh_em_addr = '0;
         exp_q.delete();
      end else if (!en) begin
         fresh = 1'b0;
      end else begin
         fresh = 1'b1;
         edge_cnt++;
         if (seq_kind != 0) begin
            seq_age++;
            if (seq_kind == 1 && seq_age > FLUSH) seq_kind = 0;
            if (seq_kind == 2 && seq_age > 0)     seq_kind = 0;
         end else if (em_v || fd_v) begin
            seq_kind = 1; seq_age = 0;
            e.edge_idx = edge_cnt;
            if (em_v) begin
               seq_win = 1;
               sh_em_code = em_code; sh_em_pc = em_pc; sh_em_addr = em_addr;
               e.kind = 1; e.code = em_code; e.pc = em_pc; e.addr = em_addr;
            end else begin
               seq_win = 2;
               sh_fd_code = fd_code; sh_fd_pc = fd_pc;
               e.kind = 2; e.code = fd_code; e.pc = fd_pc; e.addr = '0;
            end
            exp_q.push_back(e);
            e.kind = 3; e.edge_idx = edge_cnt + FLUSH; e.code = '0; e.pc = '0; e.addr = '0;
            exp_q.push_back(e);
         end else if (mret) begin
            seq_kind = 2; seq_age = 0;
            e.kind = 4; e.edge_idx = edge_cnt; e.code = '0; e.pc = '0; e.addr = '0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic monitor_step();
      ev_t e;
      int act_kind;
      bit  x_trap, x_mret;
      x_trap = (seq_kind == 1);
      x_mret = (seq_kind == 2);
      check("busy",     W'(busy),   W'(x_trap || x_mret));
      check("flush",    W'(flush),  W'(x_trap || x_mret));
      check("stall_pc", W'(stall),  W'(x_trap && seq_age < FLUSH));
      check("redirect", W'(redir),  W'((x_trap && seq_age == FLUSH) || x_mret));
      check("mret_e",   W'(mret_e), W'(x_mret));
      check("strobe_em", W'(s_em),  W'(x_trap && seq_age == 0 && seq_win == 1));
      check("strobe_fd", W'(s_fd),  W'(x_trap && seq_age == 0 && seq_win == 2));
      check("em_code", W'(r_em_code), W'(sh_em_code));
      check("em_pc",   r_em_pc,   sh_em_pc);
      check("em_addr", r_em_addr, sh_em_addr);
      check("fd_code", W'(r_fd_code), W'(sh_fd_code));
      check("fd_pc",   r_fd_pc,   sh_fd_pc);
      if (!redir) check("target_idle", target, '0);
      if (fresh && (s_em || s_fd || redir)) begin
         act_kind = s_em ? 1 : s_fd ? 2 : mret_e ? 4 : 3;
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", act_kind, $time);
         end else begin
            e = exp_q.pop_front();
            check("ev_kind", W'(act_kind), W'(e.kind));
            check("ev_edge", W'(edge_cnt), W'(e.edge_idx));
            if (e.kind == 1) begin
               check("ev_em_code", W'(r_em_code), W'(e.code));
               check("ev_em_pc",   r_em_pc,   e.pc);
               check("ev_em_addr", r_em_addr, e.addr);
            end else if (e.kind == 2) begin
               check("ev_fd_code", W'(r_fd_code), W'(e.code));
               check("ev_fd_pc",   r_fd_pc,   e.pc);
            end else if (e.kind == 3) begin
               check("ev_trap_target", target, {mtvec[W-1:2], 2'b00});
            end else begin
               check("ev_mret_target", target, mepc);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(posedge clk);
      #1;
      monitor_step();
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic req_idle();
      fd_v = 1'b0; em_v = 1'b0; mret = 1'b0;
   endtask

   task automatic req_em(input logic [3:0] c, input logic [W-1:0] p, input logic [W-1:0] a);
      em_v = 1'b1; em_code = c; em_pc = p; em_addr = a;
   endtask

   task automatic req_fd(input logic [3:0] c, input logic [W-1:0] p);
      fd_v = 1'b1; fd_code = c; fd_pc = p;
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; req_idle();
      fd_code = '0; em_code = '0; fd_pc = '0; em_pc = '0; em_addr = '0;
      mtvec = '0; mepc = '0;
      step(3);
      rst = 1'b1;
      step(2);

      // single E/M trap
      mtvec = 64'h8001;
      req_em(4'h5, 64'h1000, 64'hDEAD); step(1); req_idle(); step(6);

      // E/M and F/D together: E/M wins
      req_em(4'h7, 64'h2000, 64'h44); req_fd(4'h2, 64'h3000); step(1); req_idle(); step(6);

      // F/D alone, so its registers move once
      req_fd(4'h9, 64'h3300); step(1); req_idle(); step(6);

      // mret alone
      mepc = 64'h2004; mret = 1'b1; step(1); req_idle(); step(4);

      // mret dropped by a simultaneous trap; F/D during flush ignored
      mret = 1'b1; req_em(4'h3, 64'h4000, 64'h88); step(1); req_idle();
      req_fd(4'h1, 64'h5000); step(1); req_idle(); step(6);

      // clock-enable freeze inside TRAP_FLUSH
      req_em(4'hC, 64'h6000, 64'h99); step(1); req_idle(); step(1);
      en = 1'b0; step(3); en = 1'b1; step(6);

      // reset mid-sequence
      req_em(4'hB, 64'h7000, 64'hAA); step(1); req_idle(); step(1);
      rst = 1'b0; step(1); rst = 1'b1; step(4);

      // randomized traffic with live mtvec/mepc
      for (int i = 0; i < 800; i++) begin
         em_v = ($urandom_range(0, 3) == 0);
         fd_v = ($urandom_range(0, 3) == 0);
         mret = ($urandom_range(0, 4) == 0);
         em_code = 4'($urandom_range(0, 15));
         fd_code = 4'($urandom_range(0, 15));
         em_pc   = {$urandom, $urandom};
         em_addr = {$urandom, $urandom};
         fd_pc   = {$urandom, $urandom};
         mtvec   = {$urandom, $urandom};
         mepc    = {$urandom, $urandom};
         en      = ($urandom_range(0, 9) != 0);
         rst     = ($urandom_range(0, 99) != 0);
         step(1);
      end

      req_idle(); en = 1'b1; rst = 1'b1;
      step(10);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Pipeline-side counterpart of the machine-mode CSR unit: collects raw exception reports and decoded mret from the pipeline stages and arbitrates them.
- Registers the winning trap into the `_ff` exception-code/PC/addr form the CSR file consumes, and sequences the pipeline flush.
- Redirects the PC to the mtvec base on a trap, or to mepc on mret.
- Sits between the hazard/stage registers and the CSR unit; generates the CSR unit's exception and mret-execute inputs.

Parameters:
- XLEN, `XLEN_64b: datapath width code; data width W = 1<<(XLEN+4).
- FLUSH_CYCLES, 2: cycles the pipeline flush is held on a trap (1..15).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-low.
- i_clk_en  in  1  global clock enable; when low all state and outputs hold.
- i_exc_valid_f_d  in  1  fetch/decode exception present.
- i_exc_code_f_d  in  4  fetch/decode cause.
- i_exc_pc_f_d  in  W  faulting PC, fetch/decode.
- i_exc_valid_e_m  in  1  execute/memory exception present.
- i_exc_code_e_m  in  4  execute/memory cause.
- i_exc_pc_e_m  in  W  faulting PC, execute/memory.
- i_exc_addr_e_m  in  W  faulting data address (mtval).
- i_mret_d  in  1  mret decoded in D (from CSR unit).
- i_mtvec  in  W  current mtvec.
- i_mepc  in  W  current mepc.
- o_exc_valid_f_d_ff  out  1  one-cycle commit strobe, F/D trap.
- o_exception_code_f_d_ff  out  4  latched F/D cause.
- o_exception_pc_f_d_ff  out  W  latched F/D PC.
- o_exc_valid_e_m_ff  out  1  one-cycle commit strobe, E/M trap.
- o_exception_code_e_m_ff  out  4  latched E/M cause.
- o_exception_pc_e_m_ff  out  W  latched E/M PC.
- o_exception_addr_e_m_ff  out  W  latched E/M address.
- o_mret_e  out  1  one-cycle mret-execute strobe to CSR unit.
- o_flush  out  1  flush all stage registers.
- o_stall_pc  out  1  hold PC.
- o_pc_redirect  out  1  load o_redirect_target into PC.
- o_redirect_target  out  W  redirect address.
- o_busy  out  1  sequencer not in IDLE.

Behaviour:
- Reset (i_rst==0 at a rising edge): state IDLE, counter 0, all outputs 0, including the code/pc/addr registers.
- i_clk_en==0: no state change; registered outputs hold. This takes priority over everything except reset.
- FSM states: IDLE, TRAP_FLUSH, TRAP_REDIRECT, MRET_REDIRECT.
- IDLE, a valid asserted at edge N: go to TRAP_FLUSH. During cycle N+1:
  - exactly one commit strobe is high; the code/pc(/addr) registers hold the winner's values.
  - the loser's strobe is 0 and its registers are unchanged.
- Arbitration priority: E/M wins over F/D (older instruction); exception wins over mret; mret is dropped when an exception wins.
- IDLE, i_mret_d only: go to MRET_REDIRECT.
- TRAP_FLUSH:
  - o_flush=1, o_stall_pc=1, o_busy=1.
  - 4-bit counter counts 0..FLUSH_CYCLES-1; on the last count go to TRAP_REDIRECT.
  - Strobes last only the first TRAP_FLUSH cycle.
- TRAP_REDIRECT (1 cycle):
  - o_pc_redirect=1, o_redirect_target = {i_mtvec[W-1:2],2'b00}, o_flush=1, o_stall_pc=0, o_busy=1.
  - No interrupts, so vectored mode also uses the base address.
  - Next state IDLE.
- MRET_REDIRECT (1 cycle):
  - o_mret_e=1, o_pc_redirect=1, o_redirect_target=i_mepc, o_flush=1, o_busy=1.
  - Next state IDLE.
- Outside IDLE: all exception valids and i_mret_d are ignored (they belong to squashed instructions). No queuing.
- Back-to-back: a new exception in the first IDLE cycle after a redirect is accepted normally.
- Redirect targets are sampled combinationally from i_mtvec/i_mepc in the redirect cycle, so a CSR write committed in the trap cycle is seen.
- Reset mid-sequence: immediate return to IDLE, no redirect issued, strobes cleared.
- o_flush, o_stall_pc, o_pc_redirect and o_redirect_target are decoded from the registered state (Moore); no input-to-output combinational path except the targets from i_mtvec/i_mepc.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0 and o_busy=0 the cycle after release.
- E/M only, code 4'h5, pc 0x1000, addr 0xDEAD, mtvec 0x8001, FLUSH_CYCLES=2:
  - next cycle: o_exc_valid_e_m_ff=1 with code 5, pc 0x1000, addr 0xDEAD.
  - o_flush high 2 cycles, then o_pc_redirect=1 with target 0x8000.
  - then IDLE.
- E/M code 4'h7 and F/D code 4'h2 in the same cycle: only the E/M strobe fires (code 7); F/D registers keep their prior values.
- i_mret_d with mepc 0x2004: next cycle o_mret_e=1, o_pc_redirect=1, target 0x2004, o_flush=1; the cycle after, o_busy=0.
- i_mret_d and E/M exception together: trap sequence runs and o_mret_e never asserts. An F/D exception injected during TRAP_FLUSH is ignored.
- Trap accepted, then i_clk_en=0 for 3 cycles inside TRAP_FLUSH:
  - state and outputs frozen; the sequence resumes and the redirect occurs exactly FLUSH_CYCLES enabled cycles after acceptance.
  - Then reset asserted in TRAP_FLUSH: IDLE, no redirect.
